// File: rtl/input_pkg.sv
// Shared constants for the switch/button conditioning front end.
package input_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;
  localparam int unsigned SIM_STABLE_CYCLES     = 4;
  localparam int unsigned N_SW                  = 8;
  localparam int unsigned N_BTN                 = 5;

  // Counter width for a given stability window; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input: two-flop synchroniser, stability counter, debounced level
// and registered rise/fall pulses that coincide with the level update.
module debounce_bit
  import input_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = SIM_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic            s1_q;
  logic            s2_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2_q == db) begin
        // Any return to the settled level restarts the stability window.
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        db    <= s2_q;
        cnt_q <= '0;
        rise  <= s2_q;
        fall  <= ~s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Synchronises and debounces the board switches and buttons, producing clean levels
// plus one-cycle press/release/change pulses for downstream logic.
module input_debounce #(
  parameter int unsigned STABLE_CYCLES = input_pkg::DEFAULT_STABLE_CYCLES,
  parameter int unsigned N_SW          = input_pkg::N_SW,
  parameter int unsigned N_BTN         = input_pkg::N_BTN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic [N_BTN-1:0] btn,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sw_chg
);

  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .raw (sw[i]),
      .db  (sw_db[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .raw (btn[i]),
      .db  (btn_db[i]),
      .rise(btn_press[i]),
      .fall(btn_release[i])
    );
  end

  // Pulses are already registered, so this OR adds no input-to-output path.
  assign sw_chg = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_input_debounce.sv
// Randomised and directed checks of input_debounce against a window-based reference model.
module tb_input_debounce;

  localparam int unsigned S  = 4;
  localparam int unsigned NS = 8;
  localparam int unsigned NB = 5;
  localparam int unsigned NT = NS + NB;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] sw;
  logic [NB-1:0] btn;
  logic [NS-1:0] sw_db;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          sw_chg;

  input_debounce #(
    .STABLE_CYCLES(S),
    .N_SW         (NS),
    .N_BTN        (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn        (btn),
    .sw_db      (sw_db),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sw_chg     (sw_chg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: a bit's debounced level takes the synchronised value once the
  // last S synchronised samples all disagree with it; the window restarts after an update.
  logic [NT-1:0] m_s1, m_s2, m_db, m_rise, m_fall, raw_all;
  bit            win[NT][$];
  bit            started = 1'b0;
  bit            all_diff;

  always @(posedge clk) begin
    raw_all = {btn, sw};
    started = 1'b1;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < NT; i++) win[i].delete();
    end else begin
      for (int i = 0; i < NT; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        win[i].push_back(m_s2[i]);
        if (win[i].size() > S) void'(win[i].pop_front());
        all_diff = (win[i].size() == S);
        foreach (win[i][k]) if (win[i][k] == m_db[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[i]   = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = ~m_s2[i];
          win[i].delete();
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_all;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("sw_db", 32'(sw_db), 32'(m_db[NS-1:0]));
      check("btn_db", 32'(btn_db), 32'(m_db[NT-1:NS]));
      check("btn_press", 32'(btn_press), 32'(m_rise[NT-1:NS]));
      check("btn_release", 32'(btn_release), 32'(m_fall[NT-1:NS]));
      check("sw_chg", 32'(sw_chg), 32'(|(m_rise[NS-1:0] | m_fall[NS-1:0])));
    end
  end

  int press_cnt[NB];
  int rel_cnt[NB];

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
        if (btn_press[b] === 1'b1) press_cnt[b]++;
        if (btn_release[b] === 1'b1) rel_cnt[b]++;
      end
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 8'hFF;
    btn = 5'h1F;
    // Reset with all inputs high: nothing visible until edge 6 after release.
    step(3);
    check("rst_outputs", 32'({sw_db, btn_db, btn_press, btn_release, sw_chg}), 32'd0);
    rst = 1'b0;
    step(5);
    check("post_rst_e5_sw_db", 32'(sw_db), 32'h00);
    step(1);
    check("post_rst_e6_sw_db", 32'(sw_db), 32'hFF);
    check("post_rst_e6_btn_db", 32'(btn_db), 32'h1F);
    check("post_rst_e6_press", 32'(btn_press), 32'h1F);
    check("post_rst_e6_sw_chg", 32'(sw_chg), 32'd1);
    step(1);
    check("post_rst_e7_press", 32'(btn_press), 32'h00);
    check("post_rst_e7_sw_chg", 32'(sw_chg), 32'd0);

    sw  = '0;
    btn = '0;
    step(10);

    // Clean press on btn[0].
    btn = 5'h01;
    step(5);
    check("press_e5_btn_db", 32'(btn_db), 32'h00);
    step(1);
    check("press_e6_btn_db", 32'(btn_db), 32'h01);
    check("press_e6_press", 32'(btn_press), 32'h01);
    step(1);
    check("press_e7_press", 32'(btn_press), 32'h00);

    // Bounce on btn[2]: 1,0,1,0 in 2-cycle slots, then a held 1.
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      btn[2] = (k % 2 == 0);
      step(2);
    end
    btn[2] = 1'b1;
    step(5);
    check("bounce_e5_btn_db2", 32'(btn_db[2]), 32'd0);
    step(1);
    check("bounce_e6_btn_db2", 32'(btn_db[2]), 32'd1);
    step(4);
    check("bounce_press_count", 32'(press_cnt[2]), 32'd1);

    // Short glitch on sw[3].
    sw[3] = 1'b1;
    step(3);
    sw[3] = 1'b0;
    step(10);
    check("glitch_sw_db", 32'(sw_db), 32'h00);

    // Simultaneous switch and button updates.
    sw  = 8'h0F;
    btn = btn | 5'h10;
    step(6);
    check("simul_sw_db", 32'(sw_db), 32'h0F);
    check("simul_sw_chg", 32'(sw_chg), 32'd1);
    check("simul_press", 32'(btn_press), 32'h10);
    step(2);

    // Release of btn[1] interrupted by reset.
    btn[1] = 1'b1;
    step(8);
    check("rel_setup_btn_db1", 32'(btn_db[1]), 32'd1);
    clear_counts();
    btn = '0;
    sw  = '0;
    step(3);
    rst = 1'b1;
    step(2);
    check("rel_rst_outputs", 32'({sw_db, btn_db, btn_press, btn_release, sw_chg}), 32'd0);
    rst = 1'b0;
    step(10);
    check("rel_rst_release_count", 32'(rel_cnt[1]), 32'd0);
    check("rel_rst_press_count", 32'(press_cnt[1]), 32'd0);

    // Random toggling with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 9) == 0) sw[i] = ~sw[i];
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
